// File: rtl/prog_loader_ram.sv
// Program RAM loader: fills a DEPTH x DW RAM from a len/data/sum byte stream
// and holds the CPU in reset until a load with a matching checksum completes.
// Ports: clk, reset (sync, active-low), load_start, in_valid/in_data/in_ready,
//   cpu_addr/cpu_dout (async read), cpu_reset_n, busy, error, err_code.
module prog_loader_ram #(
  parameter int DEPTH   = 16,
  parameter int DW      = 8,
  parameter int TIMEOUT = 255,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_start,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  input  logic [AW-1:0] cpu_addr,
  output logic [DW-1:0] cpu_dout,
  output logic          cpu_reset_n,
  output logic          busy,
  output logic          error,
  output logic [1:0]    err_code
);

  localparam int IW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    LEN, DATA, SUM, RUN, ERR
  } state_t;

  state_t          state, state_d;
  logic [1:0]      err_code_d;
  logic [DW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW:0]     count;
  logic [7:0]      sum;
  logic [IW-1:0]   idle_cnt;
  logic            xfer;
  logic            len_ok;
  logic            last;
  logic            tmo;

  assign busy     = (state == LEN) ||
                    (state == DATA) ||
                    (state == SUM);
  assign error    = (state == ERR);
  assign in_ready = busy & ~load_start;
  assign xfer     = in_valid & in_ready;
  assign cpu_dout = mem[cpu_addr];

  assign len_ok = (in_data != 8'h00) &&
                  (32'(in_data) <= 32'(DEPTH));
  assign last   = ({1'b0, wr_ptr} == count - 1'b1);
  // idle_cnt never stores TIMEOUT itself: the
  // cycle that would reach it moves to ERR.
  assign tmo    = (TIMEOUT != 0) &&
                  (int'(idle_cnt) + 1 == TIMEOUT);

  always_ff @(posedge clk) begin
    if (!reset) state <= LEN;
    else        state <= state_d;
  end

  always_comb begin
    state_d    = state;
    err_code_d = err_code;
    if (load_start) begin
      state_d    = LEN;
      err_code_d = 2'b00;
    end else begin
      case (state)
        LEN: begin
          if (xfer) begin
            if (len_ok) begin
              state_d = DATA;
            end else begin
              state_d    = ERR;
              err_code_d = 2'b01;
            end
          end
        end
        DATA: begin
          if (xfer) begin
            if (last) state_d = SUM;
          end else if (tmo) begin
            state_d    = ERR;
            err_code_d = 2'b11;
          end
        end
        SUM: begin
          if (xfer) begin
            if (in_data == sum) begin
              state_d = RUN;
            end else begin
              state_d    = ERR;
              err_code_d = 2'b10;
            end
          end else if (tmo) begin
            state_d    = ERR;
            err_code_d = 2'b11;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset || load_start) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      sum         <= '0;
      idle_cnt    <= '0;
      err_code    <= 2'b00;
      cpu_reset_n <= 1'b0;
    end else begin
      err_code    <= err_code_d;
      cpu_reset_n <= (state_d == RUN);
      case (state)
        LEN: begin
          if (xfer && len_ok) begin
            count    <= in_data[AW:0];
            wr_ptr   <= '0;
            sum      <= '0;
            idle_cnt <= '0;
          end
        end
        DATA: begin
          if (xfer) begin
            mem[wr_ptr] <= in_data;
            sum         <= sum + in_data;
            wr_ptr      <= wr_ptr + 1'b1;
            idle_cnt    <= '0;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        SUM: begin
          if (xfer) idle_cnt <= '0;
          else      idle_cnt <= idle_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader_ram.sv
// Directed bench for prog_loader_ram (TIMEOUT=4).
// Hand-computed vectors for load, checksum, length, timeout and restart.
module tb_prog_loader_ram;

  logic       clk = 1'b0;
  logic       reset;
  logic       load_start;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [3:0] cpu_addr;
  logic [7:0] cpu_dout;
  logic       cpu_reset_n;
  logic       busy;
  logic       error;
  logic [1:0] err_code;

  int checks = 0;
  int errors = 0;

  prog_loader_ram #(
    .DEPTH(16), .DW(8), .TIMEOUT(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .load_start(load_start),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .cpu_addr(cpu_addr),
    .cpu_dout(cpu_dout),
    .cpu_reset_n(cpu_reset_n),
    .busy(busy),
    .error(error),
    .err_code(err_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    load_start = 1'b1;
    @(posedge clk);
    #1 load_start = 1'b0;
  endtask

  task automatic rd(input string tag,
                    input logic [3:0] a,
                    input logic [7:0] exp);
    cpu_addr = a;
    #1 chk(tag, cpu_dout, exp);
  endtask

  logic [7:0] exp3 [16];

  initial begin
    reset      = 1'b0;
    load_start = 1'b0;
    in_valid   = 1'b0;
    in_data    = 8'h00;
    cpu_addr   = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cpu_reset_n", cpu_reset_n, 0);
    chk("rst_busy", busy, 1);
    chk("rst_error", error, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_dout", cpu_dout, 8'h00);
    reset = 1'b1;

    // 3-byte load, sum A5+41+90 = 0x176 -> 76
    send(8'h03);
    send(8'hA5);
    send(8'h41);
    send(8'h90);
    chk("l3_pre_sum_cpu", cpu_reset_n, 0);
    chk("l3_pre_sum_busy", busy, 1);
    send(8'h76);
    chk("l3_cpu_reset_n", cpu_reset_n, 1);
    chk("l3_busy", busy, 0);
    chk("l3_error", error, 0);
    chk("l3_in_ready", in_ready, 0);
    for (int i = 0; i < 16; i++) exp3[i] = 8'h00;
    exp3[0] = 8'hA5;
    exp3[1] = 8'h41;
    exp3[2] = 8'h90;
    for (int i = 0; i < 16; i++)
      rd($sformatf("l3_mem%0d", i), 4'(i), exp3[i]);
    rd("l3_addr1", 4'd1, 8'h41);

    // load_start in RUN with a byte presented
    @(negedge clk);
    load_start = 1'b1;
    in_valid   = 1'b1;
    in_data    = 8'h02;
    #1 chk("ls_in_ready", in_ready, 0);
    chk("ls_cpu_before", cpu_reset_n, 1);
    @(posedge clk);
    #1;
    load_start = 1'b0;
    in_valid   = 1'b0;
    chk("ls_cpu_reset_n", cpu_reset_n, 0);
    chk("ls_busy", busy, 1);
    rd("ls_mem0_clr", 4'd0, 8'h00);

    // full 16-byte load; the ignored 02 must not act as a length
    send(8'h10);
    cpu_addr = 4'd0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h90;
    #1 chk("rw_old_data", cpu_dout, 8'h00);
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int i = 1; i < 16; i++) send(8'h90 + 8'(i));
    chk("l16_pre_sum_busy", busy, 1);
    send(8'h78);
    chk("l16_cpu_reset_n", cpu_reset_n, 1);
    chk("l16_error", error, 0);
    for (int i = 0; i < 16; i++)
      rd($sformatf("l16_mem%0d", i), 4'(i), 8'h90 + 8'(i));

    // checksum mismatch
    pulse_start();
    send(8'h02);
    send(8'h11);
    send(8'h22);
    send(8'h00);
    chk("cs_error", error, 1);
    chk("cs_err_code", err_code, 2'b10);
    chk("cs_cpu_reset_n", cpu_reset_n, 0);
    chk("cs_busy", busy, 0);
    chk("cs_in_ready", in_ready, 0);
    rd("cs_mem0", 4'd0, 8'h11);
    rd("cs_mem1", 4'd1, 8'h22);
    rd("cs_mem2", 4'd2, 8'h00);

    // bad lengths
    pulse_start();
    chk("len0_clr_err", err_code, 0);
    send(8'h00);
    chk("len0_error", error, 1);
    chk("len0_err_code", err_code, 2'b01);
    rd("len0_mem0", 4'd0, 8'h00);
    pulse_start();
    send(8'h11);
    chk("len17_error", error, 1);
    chk("len17_err_code", err_code, 2'b01);
    chk("len17_cpu", cpu_reset_n, 0);
    rd("len17_mem0", 4'd0, 8'h00);

    // timeout after 4 idle cycles in DATA
    pulse_start();
    send(8'h02);
    send(8'h11);
    repeat (3) @(posedge clk);
    #1;
    chk("to_idle3_busy", busy, 1);
    chk("to_idle3_error", error, 0);
    @(posedge clk);
    #1;
    chk("to_error", error, 1);
    chk("to_err_code", err_code, 2'b11);
    rd("to_mem0_kept", 4'd0, 8'h11);
    pulse_start();
    chk("to_rs_busy", busy, 1);
    chk("to_rs_err_code", err_code, 0);
    chk("to_rs_error", error, 0);
    rd("to_rs_mem0", 4'd0, 8'h00);

    // reset mid-DATA
    send(8'h03);
    send(8'hA5);
    rd("mr_mem0_pre", 4'd0, 8'hA5);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("mr_busy", busy, 1);
    chk("mr_cpu", cpu_reset_n, 0);
    chk("mr_error", error, 0);
    chk("mr_err_code", err_code, 0);
    rd("mr_mem0", 4'd0, 8'h00);
    reset = 1'b1;
    // fresh length accepted after reset
    send(8'h01);
    send(8'h5A);
    send(8'h5A);
    chk("mr_reload_cpu", cpu_reset_n, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
